// File: rtl/noc_ctrl_pkg.sv
// Shared definitions for the NoC traffic run controller.
// Holds the phase encodings driven on traffic_phase_ctrl.phase so that
// monitors and the controller decode the same values.
package noc_ctrl_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_RST  = 3'd1,
    PH_SEND = 3'd2,
    PH_COOL = 3'd3,
    PH_DONE = 3'd4
  } phase_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable phase timer.
// A down-counter (rem) measures the remaining cycles of the current phase,
// and an up-counter (count) reports cycles elapsed since the last load.
//   clk, reset   : clock, async active-low reset
//   load         : restart the phase; rem <= load_val, count <= 0
//   load_val     : phase length minus one
//   count        : cycles elapsed in the phase (registered)
//   count_nxt    : value count takes on the next edge
//   expire       : current cycle is the last cycle of the phase
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             expire
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = load_val;
      cnt_d = '0;
    end else if (rem_q != '0) begin
      // Both counters freeze at terminal count, so count never wraps.
      rem_d = rem_q - 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign count     = cnt_q;
  assign count_nxt = cnt_d;
  assign expire    = (rem_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Run controller for one NoC traffic experiment:
// network reset hold -> injection window -> cooldown -> completion.
//
//   state | meaning
//   IDLE  | waiting for start, network held in reset
//   RST   | network reset held for RESET_CYCLES
//   SEND  | injection window, SIM_CYCLES, node i enabled from cycle i*STAGGER
//   COOL  | cooldown, COOLDOWN_CYCLES, abort ignored, drained captured at end
//   DONE  | run complete, waiting for restart or abort
//
// Ports: clk, reset (async active-low), start, abort, net_idle in;
// net_reset, send, node_send[NUM_NODES], phase[3], done, drained,
// cycle_cnt[CNT_W] out. All outputs are flops.
module traffic_phase_ctrl
  import noc_ctrl_pkg::*;
#(
  parameter int NUM_NODES       = 9,
  parameter int RESET_CYCLES    = 5,
  parameter int SIM_CYCLES      = 2500,
  parameter int COOLDOWN_CYCLES = 1250,
  parameter int STAGGER         = 1,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 net_idle,
  output logic                 net_reset,
  output logic                 send,
  output logic [NUM_NODES-1:0] node_send,
  output logic [PHASE_W-1:0]   phase,
  output logic                 done,
  output logic                 drained,
  output logic [CNT_W-1:0]     cycle_cnt
);

  phase_e state_q, state_d;

  logic                 net_reset_q, net_reset_d;
  logic                 send_q, send_d;
  logic [NUM_NODES-1:0] node_send_q, node_send_d;
  logic                 done_q, done_d;
  logic                 drained_q, drained_d;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_load_val;
  logic [CNT_W-1:0]     tmr_count;
  logic [CNT_W-1:0]     tmr_count_nxt;
  logic                 tmr_expire;
  logic [31:0]          cnt_ext;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PH_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort takes priority over start everywhere it applies.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_IDLE: if (!abort && start) state_d = PH_RST;
      PH_RST: begin
        if (abort)           state_d = PH_IDLE;
        else if (tmr_expire) state_d = PH_SEND;
      end
      PH_SEND: if (abort || tmr_expire) state_d = PH_COOL;
      PH_COOL: if (tmr_expire) state_d = PH_DONE;
      PH_DONE: begin
        if (abort)      state_d = PH_IDLE;
        else if (start) state_d = PH_RST;
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // Reload on every phase change; IDLE/DONE reload every cycle to pin count at 0.
  always_comb begin
    tmr_load     = (state_d != state_q) || (state_d == PH_IDLE) || (state_d == PH_DONE);
    tmr_load_val = '0;
    unique case (state_d)
      PH_RST:  tmr_load_val = CNT_W'(RESET_CYCLES - 1);
      PH_SEND: tmr_load_val = CNT_W'(SIM_CYCLES - 1);
      PH_COOL: tmr_load_val = CNT_W'(COOLDOWN_CYCLES - 1);
      default: tmr_load_val = '0;
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .count     (tmr_count),
    .count_nxt (tmr_count_nxt),
    .expire    (tmr_expire)
  );

  // Output logic: decoded from the next state and next count so every
  // output is a flop aligned with phase and cycle_cnt.
  always_comb begin
    cnt_ext     = 32'(tmr_count_nxt);
    net_reset_d = (state_d == PH_IDLE) || (state_d == PH_RST);
    send_d      = (state_d == PH_SEND);
    done_d      = (state_d == PH_DONE);
    // Nodes whose offset is beyond the window never satisfy the compare,
    // since the count stops at SIM_CYCLES-1.
    for (int i = 0; i < NUM_NODES; i++) begin
      node_send_d[i] = send_d && (cnt_ext >= 32'(i * STAGGER));
    end
    drained_d = drained_q;
    if (state_d == PH_RST)                     drained_d = 1'b0;
    else if (state_q == PH_COOL && tmr_expire) drained_d = net_idle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      net_reset_q <= 1'b1;
      send_q      <= 1'b0;
      node_send_q <= '0;
      done_q      <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      net_reset_q <= net_reset_d;
      send_q      <= send_d;
      node_send_q <= node_send_d;
      done_q      <= done_d;
      drained_q   <= drained_d;
    end
  end

  assign net_reset = net_reset_q;
  assign send      = send_q;
  assign node_send = node_send_q;
  assign done      = done_q;
  assign drained   = drained_q;
  assign phase     = state_q;
  assign cycle_cnt = tmr_count;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: two instances sharing stimulus,
// STAGGER=1 (u_dut) and STAGGER=3 (u_dut_s3), RESET=5, SIM=20, COOL=10.
module tb_traffic_phase_ctrl;

  localparam int NN = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, net_idle;

  logic          net_reset, send, done, drained;
  logic [NN-1:0] node_send;
  logic [2:0]    phase;
  logic [15:0]   cycle_cnt;

  logic          net_reset3, send3, done3, drained3;
  logic [NN-1:0] node_send3;
  logic [2:0]    phase3;
  logic [15:0]   cycle_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_NODES(NN), .RESET_CYCLES(5), .SIM_CYCLES(20),
    .COOLDOWN_CYCLES(10), .STAGGER(1), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .net_idle(net_idle),
    .net_reset(net_reset), .send(send), .node_send(node_send), .phase(phase),
    .done(done), .drained(drained), .cycle_cnt(cycle_cnt)
  );

  traffic_phase_ctrl #(
    .NUM_NODES(NN), .RESET_CYCLES(5), .SIM_CYCLES(20),
    .COOLDOWN_CYCLES(10), .STAGGER(3), .CNT_W(16)
  ) u_dut_s3 (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort), .net_idle(net_idle),
    .net_reset(net_reset3), .send(send3), .node_send(node_send3), .phase(phase3),
    .done(done3), .drained(drained3), .cycle_cnt(cycle_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_net_reset"}, 32'(net_reset), 1);
    chk({tag, "_send"}, 32'(send), 0);
    chk({tag, "_node_send"}, 32'(node_send), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_drained"}, 32'(drained), 0);
    chk({tag, "_cycle_cnt"}, 32'(cycle_cnt), 0);
    chk({tag, "_s3_phase"}, 32'(phase3), 0);
    chk({tag, "_s3_node_send"}, 32'(node_send3), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; net_idle = 1'b0;
    #12;
    chk_reset_vals("rst");
    #10 rst_n = 1'b1;
    cyc(1);
    chk("idle_phase", 32'(phase), 0);
    chk("idle_net_reset", 32'(net_reset), 1);

    // Nominal run: start accepted at edge E
    start = 1'b1;
    cyc(1);                                   // E
    start = 1'b0;
    chk("rst_phase", 32'(phase), 1);
    chk("rst_cnt0", 32'(cycle_cnt), 0);
    chk("rst_net_reset", 32'(net_reset), 1);
    cyc(4);                                   // E+4
    chk("rst_cnt4", 32'(cycle_cnt), 4);
    chk("rst_send_low", 32'(send), 0);
    cyc(1);                                   // E+5
    chk("send_phase", 32'(phase), 2);
    chk("send_net_reset", 32'(net_reset), 0);
    chk("send_high", 32'(send), 1);
    chk("send_cnt0", 32'(cycle_cnt), 0);
    chk("node_send_c0", 32'(node_send), 32'h001);
    chk("s3_node_send_c0", 32'(node_send3), 32'h001);
    cyc(4);                                   // E+9, cnt 4
    chk("node_send_c4", 32'(node_send), 32'h01F);
    chk("s3_node_send_c4", 32'(node_send3), 32'h003);
    cyc(14);                                  // E+23, cnt 18
    chk("send_cnt18", 32'(cycle_cnt), 18);
    chk("node_send_c18", 32'(node_send), 32'h1FF);
    chk("s3_node_send_c18", 32'(node_send3), 32'h07F);
    cyc(1);                                   // E+24, cnt 19
    chk("send_last", 32'(send), 1);
    chk("s3_node_send_c19", 32'(node_send3), 32'h07F);
    cyc(1);                                   // E+25
    chk("cool_phase", 32'(phase), 3);
    chk("cool_send", 32'(send), 0);
    chk("cool_node_send", 32'(node_send), 0);
    chk("s3_cool_node_send", 32'(node_send3), 0);
    chk("cool_cnt0", 32'(cycle_cnt), 0);
    cyc(8);                                   // E+33
    chk("cool_cnt8", 32'(cycle_cnt), 8);
    net_idle = 1'b1;
    cyc(1);                                   // E+34, last COOL cycle
    chk("cool_last_done", 32'(done), 0);
    chk("cool_last_phase", 32'(phase), 3);
    cyc(1);                                   // E+35
    chk("done_phase", 32'(phase), 4);
    chk("done_flag", 32'(done), 1);
    chk("drained_set", 32'(drained), 1);
    chk("done_net_reset", 32'(net_reset), 0);
    chk("done_cnt", 32'(cycle_cnt), 0);
    cyc(2);
    chk("done_hold", 32'(done), 1);
    chk("drained_hold", 32'(drained), 1);
    chk("done_cnt_hold", 32'(cycle_cnt), 0);

    // Restart from DONE
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_phase", 32'(phase), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_drained", 32'(drained), 0);
    chk("restart_net_reset", 32'(net_reset), 1);

    // Abort in RST
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_rst_phase", 32'(phase), 0);
    chk("abort_rst_send", 32'(send), 0);
    cyc(1);
    chk("abort_rst_stay", 32'(phase), 0);

    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1;
    cyc(2);
    chk("both_idle_phase", 32'(phase), 0);
    chk("both_idle_send", 32'(send), 0);
    chk("both_idle_net_reset", 32'(net_reset), 1);
    start = 1'b0; abort = 1'b0;

    // Abort in SEND at cycle_cnt 7, with net_idle low at end of cooldown
    net_idle = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    chk("abrt_send_phase", 32'(phase), 2);
    cyc(7);
    chk("abrt_send_cnt7", 32'(cycle_cnt), 7);
    chk("abrt_send_high", 32'(send), 1);
    abort = 1'b1;
    cyc(1);
    chk("abrt_cool_phase", 32'(phase), 3);
    chk("abrt_send_low", 32'(send), 0);
    chk("abrt_node_send", 32'(node_send), 0);
    chk("abrt_s3_node_send", 32'(node_send3), 0);
    cyc(3);                                   // abort still high: ignored in COOL
    chk("abrt_cool_ignored", 32'(phase), 3);
    chk("abrt_cool_cnt3", 32'(cycle_cnt), 3);
    abort = 1'b0;
    cyc(6);
    chk("abrt_cool_done_low", 32'(done), 0);
    cyc(1);
    chk("abrt_done", 32'(done), 1);
    chk("abrt_drained_low", 32'(drained), 0);

    // Async reset mid-SEND
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(8);
    chk("pre_arst_send", 32'(send), 1);
    chk("pre_arst_cnt", 32'(cycle_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #3 rst_n = 1'b1;
    cyc(1);
    chk("post_arst_phase", 32'(phase), 0);
    chk("post_arst_send", 32'(send), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
